nco_scan_ctrl: RTL

Frame-level sequencer for the spectrogram NCO. On a frame trigger it walks the NCO frequency index `V_POS` over `NUM_BINS` bins. For each bin it pulses the NCO `START`, waits out the NCO's ROM/setup pipeline, and then marks a burst of `SAMPLES_PER_BIN` rotation outputs as valid for the downstream mixer/accumulator. Between bins it waits for downstream readiness, because the NCO cannot be stalled once its burst begins.

---
 rtl/nco_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nco_scan_ctrl.sv
// nco_scan_ctrl: frame-level sequencer for the spectrogram NCO.
// Walks V_POS over NUM_BINS bins. Each bin gets one NCO_START pulse, a
// setup wait, and a burst of SAMPLES_PER_BIN valid samples. A new bin
// starts only when the downstream is ready.
// Optional feature: define NCO_SCAN_OVERRUN_EN to add the sticky OVERRUN
// flag, which records frame triggers that arrive while the block is busy.
module nco_scan_ctrl #(
  parameter int NUM_BINS        = 272,
  parameter int SAMPLES_PER_BIN = 64,
  parameter int SAMPLE_W        = 7,
  parameter int SETUP_CYCLES    = 6
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                FRAME_START,
  input  logic                DS_READY,
  output logic                NCO_START,
  output logic [8:0]          V_POS,
  output logic                SAMPLE_VALID,
  output logic [SAMPLE_W-1:0] SAMPLE_IDX,
  output logic                BIN_FIRST,
  output logic                BIN_LAST,
  output logic                FRAME_DONE,
  output logic                BUSY
`ifdef NCO_SCAN_OVERRUN_EN
  ,
  output logic                OVERRUN
`endif
);

  // The setup counter only has to reach SETUP_CYCLES-2. START accounts for
  // the first cycle of the NCO pipeline, and SETUP covers the remaining
  // SETUP_CYCLES-1 cycles.
  localparam int                  SETUP_W    = $clog2(SETUP_CYCLES) + 1;
  localparam logic [SETUP_W-1:0]  SETUP_LAST = SETUP_W'(SETUP_CYCLES - 2);
  localparam logic [SAMPLE_W-1:0] IDX_LAST   = SAMPLE_W'(SAMPLES_PER_BIN - 1);
  localparam logic [8:0]          BIN_TERM   = 9'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_SETUP,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [SETUP_W-1:0]   setup_cnt, setup_cnt_n;
  logic [SAMPLE_W-1:0]  idx_n;
  logic [8:0]           bin_n;

  // Next state and next counter values. Every output is a registered
  // decode of these values, so the outputs line up with the state they
  // describe.
  always_comb begin
    state_n     = state;
    setup_cnt_n = '0;
    idx_n       = '0;
    bin_n       = V_POS;
    case (state)
      S_IDLE: begin
        if (FRAME_START) begin
          state_n = S_WAIT;
          bin_n   = '0;
        end
      end
      S_WAIT: begin
        if (DS_READY) state_n = S_START;
      end
      S_START: begin
        state_n = S_SETUP;
      end
      S_SETUP: begin
        if (setup_cnt == SETUP_LAST) state_n = S_RUN;
        else                         setup_cnt_n = setup_cnt + 1'b1;
      end
      S_RUN: begin
        // The burst cannot be stalled. DS_READY is consulted only in WAIT.
        if (SAMPLE_IDX == IDX_LAST) begin
          if (V_POS == BIN_TERM) begin
            state_n = S_DONE;
          end else begin
            state_n = S_WAIT;
            bin_n   = V_POS + 9'd1;
          end
        end else begin
          idx_n = SAMPLE_IDX + SAMPLE_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs. Reset abandons any burst in
  // progress, and no FRAME_DONE is produced for it.
  always_ff @(posedge CK) begin
    if (RST) begin
      state        <= S_IDLE;
      setup_cnt    <= '0;
      SAMPLE_IDX   <= '0;
      V_POS        <= '0;
      NCO_START    <= 1'b0;
      SAMPLE_VALID <= 1'b0;
      BIN_FIRST    <= 1'b0;
      BIN_LAST     <= 1'b0;
      FRAME_DONE   <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_n;
      setup_cnt    <= setup_cnt_n;
      SAMPLE_IDX   <= idx_n;
      V_POS        <= bin_n;
      NCO_START    <= (state_n == S_START);
      SAMPLE_VALID <= (state_n == S_RUN);
      BIN_FIRST    <= (state_n == S_RUN) && (idx_n == '0);
      BIN_LAST     <= (state_n == S_RUN) && (idx_n == IDX_LAST);
      FRAME_DONE   <= (state_n == S_DONE);
      BUSY         <= (state_n != S_IDLE);
    end
  end

`ifdef NCO_SCAN_OVERRUN_EN
  // Sticky record of a trigger that was dropped because a frame was running.
  always_ff @(posedge CK) begin
    if (RST)                      OVERRUN <= 1'b0;
    else if (FRAME_START && BUSY) OVERRUN <= 1'b1;
  end
`endif

endmodule
